// File: rtl/fpdiv_feeder.sv
// Operand FIFO and issue/collect sequencer for the half-width floating-point divider.
// Define FPDIV_TIMEOUT_EN to add the WAIT watchdog and the sticky err output.
module fpdiv_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  in_a,
    input  logic [15:0]                  in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_y,
    output logic [15:0]                  div_x1,
    output logic [15:0]                  div_x2,
    output logic                         div_en,
    input  logic [15:0]                  div_y,
    input  logic                         div_ready,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef FPDIV_TIMEOUT_EN
    ,
    output logic                         err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_next;
    logic [15:0]     mem_a [DEPTH];
    logic [15:0]     mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, done, expired;

    assign in_ready   = (count < CW'(DEPTH));
    assign fifo_count = count;
    assign push       = in_valid && in_ready;
    assign pop        = (state == IDLE) && (count != '0) && !out_valid;
    assign done       = (state == WAIT) && div_ready;
    assign div_en     = (state == ISSUE);
    assign busy       = (state != IDLE);

`ifdef FPDIV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;

    // A real result arriving on the expiry cycle takes priority over the timeout.
    assign expired = (state == WAIT) && !div_ready && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            err   <= 1'b0;
        end else begin
            timer <= (state == WAIT) ? timer + 1'b1 : '0;
            if (expired)
                err <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (div_ready || expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands stay on the divider inputs until the next pop replaces them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_x1 <= '0;
            div_x2 <= '0;
        end else if (pop) begin
            div_x1 <= mem_a[rd_ptr];
            div_x2 <= mem_b[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_y     <= '0;
            out_valid <= 1'b0;
        end else if (done) begin
            out_y     <= div_y;
            out_valid <= 1'b1;
        end else if (expired) begin
            out_y     <= 16'hFFFF;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpdiv_feeder.sv
// Scoreboard bench for fpdiv_feeder with a behavioural divider model.
// Define FPDIV_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_fpdiv_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_y, div_x1, div_x2, div_y;
    logic        div_en, div_ready, busy;
    logic [2:0]  fifo_count;
`ifdef FPDIV_TIMEOUT_EN
    logic        err;
`endif

    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_q[$];
    logic [15:0] resp_q[$];
    logic [31:0] op_q[$];
    int          lat = 3;
    bit          div_hold = 1'b0;
    bit          stray = 1'b0;
    int          en_count = 0;
    bit          prev_en = 1'b0;

    always #5 clk = ~clk;

    fpdiv_feeder #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .div_x1(div_x1), .div_x2(div_x2), .div_en(div_en),
        .div_y(div_y), .div_ready(div_ready),
        .busy(busy), .fifo_count(fifo_count)
`ifdef FPDIV_TIMEOUT_EN
        , .err(err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        $display("[TB] FAIL %s: got %h", name, act);
    endtask

    // Divider model: answers lat cycles after each div_en with the queued quotient.
    initial begin
        int          countdown = 0;
        logic [15:0] pending = '0;
        logic [31:0] op;
        div_ready = 1'b0;
        div_y     = '0;
        forever begin
            @(negedge clk);
            div_ready = 1'b0;
            if (!rst) countdown = 0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0 && !div_hold) begin
                    div_ready = 1'b1;
                    div_y     = pending;
                end
            end
            if (stray) begin
                div_ready = 1'b1;
                div_y     = 16'h1234;
            end
            if (div_en) begin
                en_count++;
                check("div_en_single_cycle", 32'(prev_en), 32'd0);
                check("no_issue_while_valid", 32'(out_valid), 32'd0);
                if (resp_q.size() == 0) begin
                    fail("div_en_unexpected", 32'(div_x1));
                end else begin
                    op      = op_q.pop_front();
                    pending = resp_q.pop_front();
                    check("div_x1", 32'(div_x1), 32'(op[31:16]));
                    check("div_x2", 32'(div_x2), 32'(op[15:0]));
                    countdown = lat;
                end
            end
            prev_en = div_en;
        end
    end

    // Output monitor: every accepted quotient must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) fail("unexpected_output", 32'(out_y));
            else check("out_y", 32'(out_y), 32'(exp_q.pop_front()));
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] y);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail("push_in_ready_timeout", 32'(fifo_count));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        exp_q.push_back(y);
        resp_q.push_back(y);
        op_q.push_back({a, b});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy || fifo_count != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) fail("wait_idle_timeout", 32'(exp_q.size()));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got %0t", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int en_before;
        int n;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_div_x1", 32'(div_x1), 32'd0);
        check("rst_div_x2", 32'(div_x2), 32'd0);
        check("rst_div_en", 32'(div_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
`ifdef FPDIV_TIMEOUT_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk) rst = 1'b1;

        $display("[TB] single op 6.0/2.0");
        out_ready = 1'b1; lat = 3;
        push(16'h40C0, 16'h4000, 16'h4040);
        check("t1_count_after_push", 32'(fifo_count), 32'd1);
        check("t1_busy_after_push", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("t1_div_en", 32'(div_en), 32'd1);
        check("t1_count_after_pop", 32'(fifo_count), 32'd0);
        wait_idle();

        $display("[TB] back-to-back five ops");
        lat = 10; en_before = en_count;
        push(16'h4100, 16'h4000, 16'h4080);
        push(16'h3F80, 16'h4000, 16'h3F00);
        push(16'h4110, 16'h4040, 16'h4040);
        push(16'hC080, 16'h4000, 16'hC000);
        push(16'h4120, 16'h4080, 16'h4020);
        check("t2_full_count", 32'(fifo_count), 32'd4);
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        wait_idle();
        check("t2_en_count", 32'(en_count - en_before), 32'd5);

        $display("[TB] output stall");
        out_ready = 1'b0; lat = 2;
        push(16'h40C0, 16'h4000, 16'h4040);
        push(16'h4100, 16'h4000, 16'h4080);
        push(16'h3F80, 16'h4000, 16'h3F00);
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        if (!out_valid) fail("t3_out_valid_timeout", 32'(n));
        en_before = en_count;
        repeat (4) @(posedge clk);
        #1;
        check("t3_stall_count", 32'(fifo_count), 32'd2);
        check("t3_stall_busy", 32'(busy), 32'd0);
        check("t3_stall_valid", 32'(out_valid), 32'd1);
        check("t3_stall_no_en", 32'(en_count - en_before), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_drained", 32'(out_valid), 32'd0);
        check("t3_no_en_on_drain", 32'(div_en), 32'd0);
        @(posedge clk); #1;
        check("t3_en_after_drain", 32'(div_en), 32'd1);
        wait_idle();

        $display("[TB] divide by zero");
        lat = 3;
        push(16'h3F80, 16'h0000, 16'h7F80);
        wait_idle();
`ifdef FPDIV_TIMEOUT_EN
        check("t4_err", 32'(err), 32'd0);
`endif

        $display("[TB] reset mid-wait");
        div_hold = 1'b1;
        push(16'h4100, 16'h4000, 16'h4080);
        push(16'h4110, 16'h4040, 16'h4040);
        push(16'h4120, 16'h4080, 16'h4020);
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        check("t5_count_before_rst", 32'(fifo_count), 32'd2);
        rst = 1'b0;
        exp_q.delete(); resp_q.delete(); op_q.delete();
        #1;
        check("t5_rst_count", 32'(fifo_count), 32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        div_hold = 1'b0;
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_stray_valid", 32'(out_valid), 32'd0);
        check("t5_stray_busy", 32'(busy), 32'd0);
        check("t5_stray_count", 32'(fifo_count), 32'd0);

`ifdef FPDIV_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        out_ready = 1'b0; div_hold = 1'b1; lat = 3;
        push(16'h40C0, 16'h4000, 16'hFFFF);
        push(16'h4100, 16'h4000, 16'h4080);
        n = 0;
        while (!div_en && n < 50) begin @(posedge clk); #1; n++; end
        if (!div_en) fail("t6_div_en_timeout", 32'(n));
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        check("t6_timeout_cycles", 32'(n), 32'd65);
        check("t6_out_y_nan", 32'(out_y), 32'h0000FFFF);
        check("t6_err_set", 32'(err), 32'd1);
        check("t6_queued", 32'(fifo_count), 32'd1);
        div_hold = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("t6_err_sticky", 32'(err), 32'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fpdiv_feeder.md
Name: fpdiv_feeder

Overview:
- Upstream issue and collect stage for the half-width (1/8/7) floating-point divider.
- Buffers operand pairs from a producer in a small FIFO and issues them to the divider one at a time.
- Drives the divider's x1/x2/en inputs, waits for its ready pulse, and holds the quotient in an output register behind a valid/ready handshake.
- Exactly one division is in flight at any time.

Parameters:
- DEPTH, 4: operand FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT, 64: watchdog limit in WAIT, in cycles. Used only when FPDIV_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer presents an operand pair.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH). Does not depend on a same-cycle pop.
- in_a  in  16  dividend.
- in_b  in  16  divisor.
- out_valid  out  1  out_y holds an unconsumed quotient.
- out_ready  in  1  consumer accepts out_y.
- out_y  out  16  quotient.
- div_x1  out  16  to divider x1; registered.
- div_x2  out  16  to divider x2; registered.
- div_en  out  1  to divider en; single-cycle pulse.
- div_y  in  16  from divider y.
- div_ready  in  1  from divider ready; div_y is valid in the same cycle.
- busy  out  1  high whenever state is not IDLE.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- err  out  1  timeout sticky flag; present only with FPDIV_TIMEOUT_EN.

Behaviour:
- Reset values, while rst=0, asynchronously:
  - state=IDLE; FIFO pointers and count = 0.
  - in_ready=1; out_valid=0; out_y=0; div_x1=0; div_x2=0; div_en=0; busy=0; err=0.
- FIFO:
  - Push on in_valid && in_ready. Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push when full is impossible because in_ready=0. A pop when empty never happens.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when count>0 and out_valid=0. On that edge: pop the head, load div_x1=a and div_x2=b.
  - ISSUE: div_en=1 for exactly this one cycle, then WAIT. div_x1/div_x2 are stable throughout.
  - WAIT -> IDLE on div_ready=1. On that edge: out_y<=div_y, out_valid<=1.
  - div_x1/div_x2 hold their values after the issue until the next pop.
- div_ready outside WAIT is ignored. This covers a stale pulse after reset and a pulse during ISSUE.
- Output register:
  - out_valid clears on out_valid && out_ready.
  - No new issue while out_valid=1, so a completing result always finds the slot empty.
  - A drain in cycle N allows IDLE->ISSUE at edge N+1 at the earliest.
- Latency example, idle block with empty FIFO:
  - Push at edge k.
  - Pop/load at edge k+1.
  - div_en high in cycle k+1..k+2.
  - WAIT from edge k+2.
  - out_valid rises on the edge after div_ready is seen.
- Throughput: one division per (divider latency + 3) cycles, plus any consumer stall.
- Reset mid-operation (any state): all state is discarded, including FIFO contents and any in-flight result. The divider itself is reset by the same rst.

Optional Feature:
FPDIV_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT. If TIMEOUT cycles elapse without div_ready, the FSM goes to IDLE.
  - On that edge it loads out_y=16'hFFFF (NaN), sets out_valid=1 and sets err=1.
  - err is sticky until reset. The counter clears on every entry to WAIT.
  - If div_ready arrives in the same cycle the counter expires, the real result wins and err is unchanged.
- Not defined: no counter and no err port. WAIT holds indefinitely.

Test Plan:
- Single op, out_ready=1: push a=16'h40C0 (6.0), b=16'h4000 (2.0); model div_ready 3 cycles after div_en with div_y=16'h4040.
  -> div_en is one cycle with div_x1=16'h40C0, div_x2=16'h4000; out_y=16'h4040 with out_valid for 1 cycle.
- Back-to-back: push 5 pairs with out_ready=1 and divider latency 10.
  -> in_ready drops after 4 accepted (count=4); all 5 results emerge in push order, with exactly one div_en per result.
- Output stall: complete one op with out_ready=0 and 2 pairs queued.
  -> no div_en while out_valid=1; first div_en for the queue follows the edge where out_ready=1 drains out_y.
- Divide-by-zero pass-through: a=16'h3F80, b=16'h0000; divider returns 16'h7F80.
  -> out_y=16'h7F80; err=0.
- Reset mid-WAIT: rst=0 for 1 cycle while 2 entries are queued; then drive a stray div_ready=1.
  -> fifo_count=0, out_valid=0, busy=0; the stray pulse produces no output.
- Timeout (FPDIV_TIMEOUT_EN, TIMEOUT=64): issue an op, never assert div_ready.
  -> after 64 WAIT cycles out_y=16'hFFFF, out_valid=1, err=1; the next queued pair issues normally after the drain.
